// File: rtl/memwb_skid_reg.sv
// MEM/WB pipeline register with valid/ready handshake, 2-entry skid buffer, flush and zero-register write guard.
// Optional stall/flush performance counters are enabled by defining MEMWB_PERF_CNT_EN.
module memwb_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int ZERO_GUARD = 1
`ifdef MEMWB_PERF_CNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_wb,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regw,
    output logic              out_memtoreg,
    output logic [DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0] out_alu,
    output logic [REG_W-1:0]  out_rd,
    output logic [DATA_W-1:0] out_wdata
`ifdef MEMWB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Entry layout: {RegWrite, MemToReg, rdata, alu, rd}
    localparam int ENT_W = 2 + 2 * DATA_W + REG_W;

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [ENT_W-1:0] o_ent_q, o_ent_d;
    logic [ENT_W-1:0] s_ent_q, s_ent_d;
    logic [ENT_W-1:0] in_ent_s;
    logic             accept_s;
    logic             drain_s;

    assign in_ent_s = {in_wb, in_rdata, in_alu, in_rd};
    assign accept_s = in_valid && in_ready_q;
    assign drain_s  = out_valid_q && out_ready;

    // Next-state selection: flush wins, then skid refill, direct load, skid capture, drain.
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        in_ready_d   = in_ready_q;
        o_ent_d      = o_ent_q;
        s_ent_d      = s_ent_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            in_ready_d   = 1'b1;
        end else if (skid_valid_q && (!out_valid_q || out_ready)) begin
            o_ent_d      = s_ent_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
            in_ready_d   = 1'b1;
        end else if (!skid_valid_q && accept_s && (!out_valid_q || out_ready)) begin
            o_ent_d      = in_ent_s;
            out_valid_d  = 1'b1;
        end else if (!skid_valid_q && accept_s) begin
            // O is stalled: park the new entry so in_ready can drop a cycle late without loss
            s_ent_d      = in_ent_s;
            skid_valid_d = 1'b1;
            in_ready_d   = 1'b0;
        end else if (drain_s) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            o_ent_q      <= {ENT_W{1'b0}};
            s_ent_q      <= {ENT_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            o_ent_q      <= o_ent_d;
            s_ent_q      <= s_ent_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_rd       = o_ent_q[REG_W-1:0];
    assign out_alu      = o_ent_q[REG_W +: DATA_W];
    assign out_rdata    = o_ent_q[REG_W + DATA_W +: DATA_W];
    assign out_memtoreg = o_ent_q[ENT_W-2];
    assign out_wdata    = out_memtoreg ? out_rdata : out_alu;
    assign out_regw     = o_ent_q[ENT_W-1] && out_valid_q &&
                          !((ZERO_GUARD != 0) && (out_rd == {REG_W{1'b0}}));

`ifdef MEMWB_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush && (out_valid_q || skid_valid_q) && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_memwb_skid_reg.sv
// Randomized bench for memwb_skid_reg checked against a queue-based FIFO model (capacity 2).
module tb_memwb_skid_reg;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  in_wb;
    logic [31:0] in_rdata, in_alu;
    logic [4:0]  in_rd;
    logic        in_ready, out_valid, out_regw, out_memtoreg;
    logic [31:0] out_rdata, out_alu, out_wdata;
    logic [4:0]  out_rd;
    logic        z_in_ready, z_out_valid, z_out_regw, z_out_memtoreg;
    logic [31:0] z_out_rdata, z_out_alu, z_out_wdata;
    logic [4:0]  z_out_rd;
`ifdef MEMWB_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt, z_stall_cnt, z_flush_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    ent_t q[$];
    int   m_stall = 0;
    int   m_flush = 0;

    always #5 clk = ~clk;

    memwb_skid_reg #(.DATA_W(32), .REG_W(5), .ZERO_GUARD(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_wb(in_wb), .in_rdata(in_rdata), .in_alu(in_alu), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_regw(out_regw),
        .out_memtoreg(out_memtoreg), .out_rdata(out_rdata), .out_alu(out_alu),
        .out_rd(out_rd), .out_wdata(out_wdata)
`ifdef MEMWB_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    memwb_skid_reg #(.DATA_W(32), .REG_W(5), .ZERO_GUARD(0)) dut_zg0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_wb(in_wb), .in_rdata(in_rdata), .in_alu(in_alu), .in_rd(in_rd),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_regw(z_out_regw),
        .out_memtoreg(z_out_memtoreg), .out_rdata(z_out_rdata), .out_alu(z_out_alu),
        .out_rd(z_out_rd), .out_wdata(z_out_wdata)
`ifdef MEMWB_PERF_CNT_EN
        , .stall_cnt(z_stall_cnt), .flush_cnt(z_flush_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare outputs with the model, then let one rising edge pass and advance the model.
    task automatic cycle();
        ent_t h;
        logic exp_v;
        logic [31:0] exp_wd;
        exp_v = (q.size() > 0);
        check_val("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
        check_val("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        check_val("zg0_out_valid", {63'd0, z_out_valid}, {63'd0, exp_v});
        check_val("zg0_in_ready", {63'd0, z_in_ready}, {63'd0, q.size() < 2});
        if (exp_v) begin
            h = q[0];
            exp_wd = h.wb[0] ? h.rdata : h.alu;
            check_val("out_rd", {59'd0, out_rd}, {59'd0, h.rd});
            check_val("out_alu", {32'd0, out_alu}, {32'd0, h.alu});
            check_val("out_rdata", {32'd0, out_rdata}, {32'd0, h.rdata});
            check_val("out_memtoreg", {63'd0, out_memtoreg}, {63'd0, h.wb[0]});
            check_val("out_wdata", {32'd0, out_wdata}, {32'd0, exp_wd});
            check_val("out_regw", {63'd0, out_regw}, {63'd0, h.wb[1] && (h.rd != 5'd0)});
            check_val("zg0_out_regw", {63'd0, z_out_regw}, {63'd0, h.wb[1]});
            check_val("zg0_out_wdata", {32'd0, z_out_wdata}, {32'd0, exp_wd});
            check_val("zg0_out_rd", {59'd0, z_out_rd}, {59'd0, h.rd});
            check_val("zg0_out_alu", {32'd0, z_out_alu}, {32'd0, h.alu});
            check_val("zg0_out_rdata", {32'd0, z_out_rdata}, {32'd0, h.rdata});
            check_val("zg0_out_memtoreg", {63'd0, z_out_memtoreg}, {63'd0, h.wb[0]});
        end else begin
            check_val("out_regw_idle", {63'd0, out_regw}, 64'd0);
            check_val("zg0_out_regw_idle", {63'd0, z_out_regw}, 64'd0);
        end
`ifdef MEMWB_PERF_CNT_EN
        check_val("stall_cnt", {48'd0, stall_cnt}, m_stall);
        check_val("flush_cnt", {48'd0, flush_cnt}, m_flush);
        check_val("zg0_stall_cnt", {48'd0, z_stall_cnt}, m_stall);
        check_val("zg0_flush_cnt", {48'd0, z_flush_cnt}, m_flush);
`endif
        @(posedge clk);
        if (q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
        if (flush && q.size() > 0 && m_flush < 65535) m_flush++;
        if (flush) begin
            q.delete();
        end else begin
            logic can_take;
            can_take = (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && can_take) q.push_back({in_wb, in_rdata, in_alu, in_rd});
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic [31:0] rdata,
                         input logic [31:0] alu, input logic [4:0] rd,
                         input logic ordy, input logic fl);
        in_valid = v; in_wb = wb; in_rdata = rdata; in_alu = alu; in_rd = rd;
        out_ready = ordy; flush = fl;
        cycle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_wb = 2'b00; in_rdata = 32'd0; in_alu = 32'd0; in_rd = 5'd0;
        @(negedge clk); @(negedge clk);
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("rst_out_regw", {63'd0, out_regw}, 64'd0);
        check_val("rst_out_memtoreg", {63'd0, out_memtoreg}, 64'd0);
        check_val("rst_out_rd", {59'd0, out_rd}, 64'd0);
        check_val("rst_out_wdata", {32'd0, out_wdata}, 64'd0);
        rst = 1'b0;

        // Passthrough, back-to-back
        drive(1'b1, 2'b10, 32'h0, 32'h10, 5'd3, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 32'h0, 32'h20, 5'd4, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 32'h0, 32'h30, 5'd5, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);

        // Stall and skid, then drain in order
        drive(1'b1, 2'b10, 32'h0, 32'h70, 5'd7, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 32'h0, 32'h80, 5'd8, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);

        // MemToReg mux and zero-register guard
        drive(1'b1, 2'b11, 32'hDEADBEEF, 32'h1234, 5'd9, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 32'hDEADBEEF, 32'h1234, 5'd9, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 32'h0, 32'h5, 5'd0, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);

        // Flush while full with an incoming entry
        drive(1'b1, 2'b10, 32'h0, 32'hA1, 5'd10, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 32'h0, 32'hA2, 5'd11, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 32'h0, 32'hA3, 5'd12, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);

        // Asynchronous reset between edges while full
        drive(1'b1, 2'b10, 32'h0, 32'hB1, 5'd13, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 32'h0, 32'hB2, 5'd14, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_val("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("arst_out_regw", {63'd0, out_regw}, 64'd0);
        q.delete(); m_stall = 0; m_flush = 0;
        #1 rst = 1'b0;
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
                  5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
